// File: rtl/mult_seq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_seq_ctrl_pkg                                          |
// | Description : Shared definitions for the multiply unit: ALU function     |
// |               codes, default widths, FSM state codes, issue packet.      |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mult_seq_ctrl_pkg;

   localparam int DEF_XLEN       = 32;
   localparam int DEF_TAG_W      = 6;
   localparam int DEF_ROB_W      = 5;
   localparam int DEF_STAGE_BITS = 8;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'h00,
      ALU_SUB    = 5'h01,
      ALU_SLT    = 5'h02,
      ALU_SLTU   = 5'h03,
      ALU_AND    = 5'h04,
      ALU_OR     = 5'h05,
      ALU_XOR    = 5'h06,
      ALU_SLL    = 5'h07,
      ALU_SRL    = 5'h08,
      ALU_SRA    = 5'h09,
      ALU_MUL    = 5'h0a,
      ALU_MULH   = 5'h0b,
      ALU_MULHSU = 5'h0c,
      ALU_MULHU  = 5'h0d
   } ALU_FUNC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } MULT_STATE;

   typedef struct packed {
      ALU_FUNC                func;
      logic [DEF_XLEN-1:0]    opa;
      logic [DEF_XLEN-1:0]    opb;
      logic [DEF_TAG_W-1:0]   tag;
      logic [DEF_ROB_W-1:0]   rob;
   } MULT_ISSUE_PACKET;

endpackage
`default_nettype wire

// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_seq_ctrl_if                                           |
// | Description : Issue / completion handshake bundle of the multiply unit.  |
// | Ports       : master = issue stage + CDB arbiter side,                   |
// |               slave  = mult_seq_ctrl side.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mult_seq_ctrl_if
   import mult_seq_ctrl_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W,
   parameter int ROB_W = DEF_ROB_W
);
   logic             issue_valid;
   logic             issue_ready;
   ALU_FUNC          issue_func;
   logic [XLEN-1:0]  issue_opa;
   logic [XLEN-1:0]  issue_opb;
   logic [TAG_W-1:0] issue_tag;
   logic [ROB_W-1:0] issue_rob;
   logic             squash;
   logic             done_valid;
   logic             done_ready;
   logic [XLEN-1:0]  done_result;
   logic [TAG_W-1:0] done_tag;
   logic [ROB_W-1:0] done_rob;
   logic             busy;

   modport master (
      output issue_valid, issue_func, issue_opa, issue_opb, issue_tag, issue_rob,
      output squash, done_ready,
      input  issue_ready, done_valid, done_result, done_tag, done_rob, busy
   );

   modport slave (
      input  issue_valid, issue_func, issue_opa, issue_opb, issue_tag, issue_rob,
      input  squash, done_ready,
      output issue_ready, done_valid, done_result, done_tag, done_rob, busy
   );
endinterface
`default_nettype wire

// File: rtl/mult_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_stage                                                 |
// | Description : One shift-add iteration: adds mcand times the low          |
// |               STAGE_BITS digit of mplier into acc, then shifts.          |
// | Ports       : i_acc/i_mcand/i_mplier in, o_*_next out (all WIDTH bits)   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_stage #(
   parameter int WIDTH      = 64,
   parameter int STAGE_BITS = 8
) (
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic [WIDTH-1:0] o_acc_next,
   output logic [WIDTH-1:0] o_mcand_next,
   output logic [WIDTH-1:0] o_mplier_next
);
   logic [WIDTH-1:0] w_digit;

   // The digit is treated as unsigned; signedness is already folded into the
   // sign-extended operands, so the product is exact modulo 2^WIDTH.
   assign w_digit       = {{(WIDTH-STAGE_BITS){1'b0}}, i_mplier[STAGE_BITS-1:0]};
   assign o_acc_next    = i_acc + (i_mcand * w_digit);
   assign o_mcand_next  = i_mcand << STAGE_BITS;
   assign o_mplier_next = i_mplier >> STAGE_BITS;
endmodule
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_seq_ctrl                                              |
// | Description : Sequencer for MUL/MULH/MULHSU/MULHU. Accepts one op, runs  |
// |               2*XLEN/STAGE_BITS shift-add iterations, then holds the     |
// |               result until the CDB arbiter takes it. Squash flushes.     |
// | Ports       : clock, reset (async, active low), bus (slave modport:      |
// |               issue_*, squash, done_*, busy)                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_seq_ctrl
   import mult_seq_ctrl_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int STAGE_BITS = DEF_STAGE_BITS,
   parameter int TAG_W      = DEF_TAG_W,
   parameter int ROB_W      = DEF_ROB_W
) (
   input  logic            clock,
   input  logic            reset,
   mult_seq_ctrl_if.slave  bus
);
   // STAGE_BITS must divide 2*XLEN; the iteration count is derived, not set.
   localparam int c_width = 2 * XLEN;
   localparam int c_iter  = c_width / STAGE_BITS;
   localparam int c_cnt_w = (c_iter > 1) ? $clog2(c_iter) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_iter - 1);

   localparam logic [1:0] c_st_idle = IDLE;
   localparam logic [1:0] c_st_busy = BUSY;
   localparam logic [1:0] c_st_done = DONE;

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_width-1:0] r_acc, r_mcand, r_mplier;
   ALU_FUNC            r_func;
   logic [TAG_W-1:0]   r_tag;
   logic [ROB_W-1:0]   r_rob;
   logic [XLEN-1:0]    r_done_result;

   MULT_ISSUE_PACKET   w_issue;
   logic               w_issue_ready, w_accept;
   logic               w_opa_signed, w_opb_signed;
   logic [c_width-1:0] w_opa_ext, w_opb_ext;
   logic [c_width-1:0] w_acc_next, w_mcand_next, w_mplier_next;
   logic [XLEN-1:0]    w_result;

   always_comb begin
      w_issue.func = bus.issue_func;
      w_issue.opa  = bus.issue_opa;
      w_issue.opb  = bus.issue_opb;
      w_issue.tag  = bus.issue_tag;
      w_issue.rob  = bus.issue_rob;
   end

   // A completing op frees the unit in the same cycle it is taken, which
   // gives back-to-back issue without a bubble.
   assign w_issue_ready = ~bus.squash &
                          ((r_state == c_st_idle) |
                           ((r_state == c_st_done) & bus.done_ready));
   assign w_accept      = bus.issue_valid & w_issue_ready;

   // MUL only uses the low half, which is identical for any extension.
   assign w_opa_signed = (w_issue.func == ALU_MULH) | (w_issue.func == ALU_MULHSU);
   assign w_opb_signed = (w_issue.func == ALU_MULH);
   assign w_opa_ext    = {{XLEN{w_opa_signed & w_issue.opa[XLEN-1]}}, w_issue.opa};
   assign w_opb_ext    = {{XLEN{w_opb_signed & w_issue.opb[XLEN-1]}}, w_issue.opb};

   mult_stage #(
      .WIDTH      (c_width),
      .STAGE_BITS (STAGE_BITS)
   ) u_stage (
      .i_acc         (r_acc),
      .i_mcand       (r_mcand),
      .i_mplier      (r_mplier),
      .o_acc_next    (w_acc_next),
      .o_mcand_next  (w_mcand_next),
      .o_mplier_next (w_mplier_next)
   );

   // Half selection is made from the final accumulation so the result
   // register is loaded on the same edge the FSM enters DONE.
   always_comb begin
      w_result = '0;
      case (r_func)
         ALU_MUL:                         w_result = w_acc_next[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: w_result = w_acc_next[c_width-1:XLEN];
         default:                         w_result = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= c_st_idle;
         r_cnt         <= '0;
         r_acc         <= '0;
         r_mcand       <= '0;
         r_mplier      <= '0;
         r_func        <= ALU_ADD;
         r_tag         <= '0;
         r_rob         <= '0;
         r_done_result <= '0;
      end else if (bus.squash) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_st_busy: begin
               r_acc    <= w_acc_next;
               r_mcand  <= w_mcand_next;
               r_mplier <= w_mplier_next;
               r_cnt    <= r_cnt + c_cnt_w'(1);
               if (r_cnt == c_cnt_last) begin
                  r_state       <= c_st_done;
                  r_cnt         <= '0;
                  r_done_result <= w_result;
               end
            end
            c_st_done: begin
               if (bus.done_ready) r_state <= c_st_idle;
            end
            c_st_idle: ;
            default:   r_state <= c_st_idle;
         endcase
         // Accept overrides the DONE->IDLE move above.
         if (w_accept) begin
            r_state  <= c_st_busy;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= w_opa_ext;
            r_mplier <= w_opb_ext;
            r_func   <= w_issue.func;
            r_tag    <= w_issue.tag;
            r_rob    <= w_issue.rob;
         end
      end
   end

   assign bus.issue_ready = w_issue_ready;
   assign bus.done_valid  = (r_state == c_st_done);
   assign bus.done_result = r_done_result;
   assign bus.done_tag    = r_tag;
   assign bus.done_rob    = r_rob;
   assign bus.busy        = (r_state != c_st_idle);
endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mult_seq_ctrl                                           |
// | Description : Directed self-checking bench for mult_seq_ctrl.            |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mult_seq_ctrl;
   import mult_seq_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   ALU_FUNC     s_func [10];
   logic [31:0] s_a [10];
   logic [31:0] s_b [10];
   logic [31:0] s_exp [10];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mult_seq_ctrl_if bus ();

   mult_seq_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input logic [4:0] r);
      bus.issue_valid = 1'b1;
      bus.issue_func  = f;
      bus.issue_opa   = a;
      bus.issue_opb   = b;
      bus.issue_tag   = t;
      bus.issue_rob   = r;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
   endtask

   // Issue one op with done_ready high and check the full completion.
   task automatic run_op(input string tag, input ALU_FUNC f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t, input logic [4:0] r,
                         input logic [31:0] exp);
      int lat;
      drive(f, a, b, t, r);
      step();
      bus.issue_valid = 1'b0;
      wait_done(lat);
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_result"}, bus.done_result, exp);
      chk({tag, "_tag"}, bus.done_tag, t);
      step();
      chk({tag, "_consumed"}, bus.done_valid, 0);
   endtask

   function automatic logic [31:0] ref_mul(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = longint'(a);
      ub = longint'(b);
      case (f)
         ALU_MUL:    begin p = ua * ub; return p[31:0];  end
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         default:    return 32'h0;
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int prev;
      logic seen;

      bus.issue_valid = 1'b0;
      bus.issue_func  = ALU_ADD;
      bus.issue_opa   = '0;
      bus.issue_opb   = '0;
      bus.issue_tag   = '0;
      bus.issue_rob   = '0;
      bus.squash      = 1'b0;
      bus.done_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_done_valid", bus.done_valid, 0);
      chk("rst_done_result", bus.done_result, 0);
      chk("rst_done_tag", bus.done_tag, 0);
      chk("rst_done_rob", bus.done_rob, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clock) reset = 1'b1;
      step();
      chk("idle_issue_ready", bus.issue_ready, 1);

      // MUL 7 x -3 with latency and echo checks
      drive(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 6'd5, 5'd3);
      step();
      bus.issue_valid = 1'b0;
      chk("mul1_busy", bus.busy, 1);
      wait_done(lat);
      chk("mul1_latency", lat, 8);
      chk("mul1_result", bus.done_result, 32'hFFFF_FFEB);
      chk("mul1_tag", bus.done_tag, 5);
      chk("mul1_rob", bus.done_rob, 3);
      step();
      chk("mul1_consumed", bus.done_valid, 0);
      chk("mul1_idle", bus.busy, 0);

      run_op("mulh",   ALU_MULH,   32'h8000_0000, 32'h8000_0000, 6'd6, 5'd4, 32'h4000_0000);
      run_op("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 5'd5, 32'hFFFF_FFFE);
      run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8, 5'd6, 32'hFFFF_FFFF);
      run_op("nonmul", ALU_ADD,    32'd3,         32'd5,         6'd9, 5'd7, 32'h0);

      // Backpressure, then same-edge consume + accept
      bus.done_ready = 1'b0;
      drive(ALU_MUL, 32'd3, 32'd4, 6'd9, 5'd1);
      step();
      drive(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 6'd10, 5'd2);
      wait_done(lat);
      chk("bp_latency", lat, 8);
      chk("bp_result", bus.done_result, 12);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold_valid", bus.done_valid, 1);
         chk("bp_hold_result", bus.done_result, 12);
         chk("bp_hold_tag", bus.done_tag, 9);
         chk("bp_issue_ready", bus.issue_ready, 0);
      end
      bus.done_ready = 1'b1;
      #1;
      chk("b2b_issue_ready", bus.issue_ready, 1);
      step();
      bus.issue_valid = 1'b0;
      chk("b2b_valid_drop", bus.done_valid, 0);
      chk("b2b_busy", bus.busy, 1);
      wait_done(lat);
      chk("b2b_latency", lat, 8);
      chk("b2b_result", bus.done_result, 1);
      chk("b2b_tag", bus.done_tag, 10);
      chk("b2b_rob", bus.done_rob, 2);
      step();

      // Squash in the third BUSY cycle
      drive(ALU_MUL, 32'd3, 32'd5, 6'd11, 5'd4);
      step();
      bus.issue_valid = 1'b0;
      step();
      step();
      bus.squash = 1'b1;
      #1;
      chk("sq_busy_ready", bus.issue_ready, 0);
      step();
      bus.squash = 1'b0;
      chk("sq_busy_idle", bus.busy, 0);
      chk("sq_busy_no_done", bus.done_valid, 0);
      seen = 1'b0;
      repeat (12) begin
         step();
         if (bus.done_valid === 1'b1) seen = 1'b1;
      end
      chk("sq_busy_never_done", seen, 0);

      // Squash in DONE with done_ready high: result dropped, no accept
      bus.done_ready = 1'b0;
      drive(ALU_MUL, 32'd2, 32'd9, 6'd12, 5'd5);
      step();
      bus.issue_valid = 1'b0;
      wait_done(lat);
      chk("sq_done_latency", lat, 8);
      chk("sq_done_result", bus.done_result, 18);
      bus.done_ready = 1'b1;
      bus.squash = 1'b1;
      drive(ALU_MUL, 32'd1, 32'd1, 6'd13, 5'd6);
      #1;
      chk("sq_done_ready", bus.issue_ready, 0);
      step();
      bus.squash = 1'b0;
      bus.issue_valid = 1'b0;
      chk("sq_done_dropped", bus.done_valid, 0);
      chk("sq_done_no_accept", bus.busy, 0);

      // Asynchronous reset in the middle of BUSY
      drive(ALU_MUL, 32'h1234, 32'h10, 6'd14, 5'd7);
      step();
      bus.issue_valid = 1'b0;
      step();
      step();
      step();
      chk("arst_pre_busy", bus.busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_done_valid", bus.done_valid, 0);
      chk("arst_done_result", bus.done_result, 0);
      chk("arst_done_tag", bus.done_tag, 0);
      chk("arst_done_rob", bus.done_rob, 0);
      chk("arst_busy", bus.busy, 0);
      @(negedge clock) reset = 1'b1;
      step();
      run_op("post_rst", ALU_MUL, 32'd3, 32'd5, 6'd15, 5'd8, 32'd15);

      // Back-to-back random stream
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 3))
            0:       s_func[i] = ALU_MUL;
            1:       s_func[i] = ALU_MULH;
            2:       s_func[i] = ALU_MULHSU;
            default: s_func[i] = ALU_MULHU;
         endcase
         s_a[i]   = $urandom;
         s_b[i]   = $urandom;
         s_exp[i] = ref_mul(s_func[i], s_a[i], s_b[i]);
      end
      bus.done_ready = 1'b1;
      drive(s_func[0], s_a[0], s_b[0], 6'd0, 5'd0);
      step();
      drive(s_func[1], s_a[1], s_b[1], 6'd1, 5'd1);
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         wait_done(lat);
         if (i == 0) chk("stream_latency", lat, 8);
         else        chk("stream_gap", cyc - prev, 9);
         prev = cyc;
         chk("stream_result", bus.done_result, s_exp[i]);
         chk("stream_tag", bus.done_tag, i);
         step();
         if (i + 2 < 10) drive(s_func[i+2], s_a[i+2], s_b[i+2], 6'(i + 2), 5'(i + 2));
         else            bus.issue_valid = 1'b0;
      end
      step();
      chk("stream_end_idle", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
